// File: rtl/alu_seq_pkg.sv
// Shared types and ALU select encodings for the multi-cycle ALU sequencer.
// Select constants are common to the ALU, the decoder and this sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD32 = 2'b00,
    OP_SUB32 = 2'b01,
    OP_MULU  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

endpackage

// File: rtl/alu_seq.sv
// Sequences the shared W-bit ALU through 2W-bit add/subtract (low then high
// half) and a WxW unsigned shift-add multiply, with start/busy/done handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned MUL_ITERS = W
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start_in,
  input  logic [1:0]     op_in,
  input  logic [2*W-1:0] a_in,
  input  logic [2*W-1:0] b_in,
  output logic           busy_out,
  output logic           done_out,
  output logic [2*W-1:0] result_out,
  output logic           carry_out,
  output logic           err_out,
  output logic [W-1:0]   alu_a_out,
  output logic [W-1:0]   alu_b_out,
  output logic [3:0]     alu_sel_out,
  output logic           alu_c_out,
  input  logic [W-1:0]   alu_y_in,
  input  logic           alu_co_in
);

  localparam int unsigned CW = $clog2(MUL_ITERS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(MUL_ITERS - 1);

  state_e         state_q,  state_d;
  op_e            op_q,     op_d;
  logic [2*W-1:0] a_q,      a_d;
  logic [2*W-1:0] b_q,      b_d;
  logic [2*W-1:0] result_q, result_d;
  logic           carry_q,  carry_d;
  logic           err_q,    err_d;
  logic           cin_q,    cin_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic [W-1:0]   mcand_q,  mcand_d;
  logic [CW-1:0]  cnt_q,    cnt_d;

  logic           is_sub;
  logic [2*W-1:0] mul_shift;

  assign is_sub    = (op_q == OP_SUB32);
  // 33-bit {carry, sum, multiplier} shifted right by one, keeping the top 32.
  assign mul_shift = {alu_co_in, alu_y_in, acc_lo_q[W-1:1]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    err_d       = err_q;
    cin_d       = cin_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    alu_a_out   = '0;
    alu_b_out   = '0;
    alu_sel_out = ALU_ADD;
    alu_c_out   = 1'b0;
    busy_out    = 1'b0;
    done_out    = 1'b0;

    case (state_q)
      ST_LO: begin
        busy_out  = 1'b1;
        alu_a_out = a_q[W-1:0];
        alu_b_out = is_sub ? ~b_q[W-1:0] : b_q[W-1:0];
        alu_c_out = is_sub;
        result_d[W-1:0] = alu_y_in;
        cin_d     = alu_co_in;
        state_d   = ST_HI;
      end
      ST_HI: begin
        busy_out  = 1'b1;
        alu_a_out = a_q[2*W-1:W];
        alu_b_out = is_sub ? ~b_q[2*W-1:W] : b_q[2*W-1:W];
        alu_c_out = cin_q;
        result_d[2*W-1:W] = alu_y_in;
        carry_d   = alu_co_in;
        state_d   = ST_DONE;
      end
      ST_MUL: begin
        busy_out  = 1'b1;
        alu_a_out = acc_hi_q;
        alu_b_out = acc_lo_q[0] ? mcand_q : '0;
        {acc_hi_d, acc_lo_d} = mul_shift;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = mul_shift;
          state_d  = ST_DONE;
        end
      end
      default: begin
        done_out = (state_q == ST_DONE);
        state_d  = ST_IDLE;
        if (start_in) begin
          op_d    = op_e'(op_in);
          a_d     = a_in;
          b_d     = b_in;
          err_d   = 1'b0;
          carry_d = 1'b0;
          cin_d   = 1'b0;
          case (op_e'(op_in))
            OP_ADD32, OP_SUB32: state_d = ST_LO;
            OP_MULU: begin
              acc_hi_d = '0;
              acc_lo_d = b_in[W-1:0];
              mcand_d  = a_in[W-1:0];
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD32;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      cin_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      cin_q    <= cin_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_out = result_q;
  assign carry_out  = carry_q;
  assign err_out    = err_q;

endmodule
